// File: rtl/riscv_pkg.sv
// Shared RV32M divider types: opcode encoding, divider FSM states and default width.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } divop_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN:0]   i_rem,
  input  logic            i_msb,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN:0]   o_rem,
  output logic            o_qbit
);

  logic [XLEN+1:0] w_shift;
  logic [XLEN+1:0] w_diff;

  // One extra guard bit above the shifted remainder exposes the borrow.
  always_comb begin
    w_shift = {i_rem, i_msb};
    w_diff  = w_shift - {2'b00, i_divisor};
    o_qbit  = ~w_diff[XLEN+1];
    o_rem   = o_qbit ? w_diff[XLEN:0] : w_shift[XLEN:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit with start/busy/done handshake.
// Optional single-entry operand/result cache enabled by defining DIV_OPCACHE_EN.
module div_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned    CW      = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      r_state, w_state_nxt;
  logic            r_qneg, r_rneg, r_op_rem;
  logic [XLEN-1:0] r_dvd, r_dvs, r_result;
  logic [XLEN:0]   r_rem;
  logic [CW-1:0]   r_cnt;

  logic [XLEN:0]   w_step_rem;
  logic            w_step_q;
  logic            w_uns, w_special, w_hit, w_accept;
  logic [XLEN-1:0] w_a_abs, w_b_abs, w_sp_q, w_sp_r, w_q_raw, w_q_fin, w_r_fin;

`ifdef DIV_OPCACHE_EN
  logic            r_c_valid, r_c_uns, r_p_uns;
  logic [XLEN-1:0] r_c_a, r_c_b, r_c_q, r_c_r, r_p_a, r_p_b;
  logic [XLEN-1:0] w_hit_res;
`endif

  div_step #(.XLEN(XLEN)) u_step (
    .i_rem     (r_rem),
    .i_msb     (r_dvd[XLEN-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_step_rem),
    .o_qbit    (w_step_q)
  );

  assign result = r_result;

  always_comb begin
    w_uns     = (divop_t'(op) == DIVU) || (divop_t'(op) == REMU);
    w_accept  = start && !flush;
    w_a_abs   = (!w_uns && a[XLEN-1]) ? -a : a;
    w_b_abs   = (!w_uns && b[XLEN-1]) ? -b : b;
    w_special = (b == '0) || (!w_uns && (a == MIN_NEG) && (b == '1));
    w_sp_q    = (b == '0) ? '1 : a;
    w_sp_r    = (b == '0) ? a  : '0;
    // Last iteration's quotient bit and remainder are folded in combinationally.
    w_q_raw   = {r_dvd[XLEN-2:0], w_step_q};
    w_q_fin   = r_qneg ? -w_q_raw : w_q_raw;
    w_r_fin   = r_rneg ? -w_step_rem[XLEN-1:0] : w_step_rem[XLEN-1:0];
`ifdef DIV_OPCACHE_EN
    w_hit     = r_c_valid && (a == r_c_a) && (b == r_c_b) && (w_uns == r_c_uns);
    w_hit_res = op[1] ? r_c_r : r_c_q;
`else
    w_hit     = 1'b0;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept) w_state_nxt = (w_special || w_hit) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (flush)             w_state_nxt = S_IDLE;
        else if (r_cnt == '0)  w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_op_rem  <= 1'b0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
`ifdef DIV_OPCACHE_EN
      r_c_valid <= 1'b0;
      r_c_uns   <= 1'b0;
      r_c_a     <= '0;
      r_c_b     <= '0;
      r_c_q     <= '0;
      r_c_r     <= '0;
      r_p_uns   <= 1'b0;
      r_p_a     <= '0;
      r_p_b     <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op_rem <= op[1];
            r_qneg   <= !w_uns && (a[XLEN-1] ^ b[XLEN-1]);
            r_rneg   <= !w_uns && a[XLEN-1];
            r_dvd    <= w_a_abs;
            r_dvs    <= w_b_abs;
            r_rem    <= '0;
            r_cnt    <= CW'(XLEN-1);
`ifdef DIV_OPCACHE_EN
            r_p_a    <= a;
            r_p_b    <= b;
            r_p_uns  <= w_uns;
`endif
            if (w_special) begin
              r_result  <= op[1] ? w_sp_r : w_sp_q;
`ifdef DIV_OPCACHE_EN
              r_c_valid <= 1'b1;
              r_c_a     <= a;
              r_c_b     <= b;
              r_c_uns   <= w_uns;
              r_c_q     <= w_sp_q;
              r_c_r     <= w_sp_r;
`endif
            end
`ifdef DIV_OPCACHE_EN
            else if (w_hit) begin
              r_result <= w_hit_res;
            end
`endif
          end
        end
        S_CALC: begin
          if (!flush) begin
            r_rem <= w_step_rem;
            r_dvd <= w_q_raw;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == '0) begin
              r_result  <= r_op_rem ? w_r_fin : w_q_fin;
`ifdef DIV_OPCACHE_EN
              r_c_valid <= 1'b1;
              r_c_a     <= r_p_a;
              r_c_b     <= r_p_b;
              r_c_uns   <= r_p_uns;
              r_c_q     <= w_q_fin;
              r_c_r     <= w_r_fin;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (XLEN=32), default and DIV_OPCACHE_EN builds.
module tb_div_unit;
  import riscv_pkg::*;

  localparam int unsigned XLEN = 32;
`ifdef DIV_OPCACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 33;
`endif

  logic            clk = 1'b0;
  logic            reset, start, flush;
  logic [1:0]      op;
  logic [XLEN-1:0] a, b, result;
  logic            busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic watch_no_done(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      tick(1);
      if (done) seen = 1'b1;
    end
    check_eq(tag, {31'b0, seen}, 32'd0);
  endtask

  // Issue one op and measure cycles from the start edge to the done pulse.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_r, input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    tick(1);
    start = 1'b0; a = '0; b = '0;
    lat = 1;
    check_eq({tag, "_busy1"}, {31'b0, busy}, 32'd1);
    while (!done && lat < 40) begin
      tick(1);
      lat++;
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_res"}, result, exp_r);
    tick(1);
    check_eq({tag, "_idle"}, {30'b0, busy, done}, 32'd0);
    check_eq({tag, "_hold"}, result, exp_r);
  endtask

  initial begin
    int lat;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    tick(2);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick(1);
    check_eq("post_rst_busy", {31'b0, busy}, 32'd0);

    run_op(DIVU, 32'd100, 32'd7, 32'd14, 33, "divu");
    run_op(REMU, 32'd100, 32'd7, 32'd2, HIT_LAT, "remu");
    run_op(DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "div_nega");
    run_op(REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, HIT_LAT, "rem_nega");
    run_op(DIV,  32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, "div_negb");

    // Flush during cycle 10 of a DIVU.
    @(negedge clk);
    op = DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(9);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check_eq("flush_busy", {31'b0, busy}, 32'd0);
    check_eq("flush_done", {31'b0, done}, 32'd0);
    check_eq("flush_result", result, 32'hFFFFFFFD);
    watch_no_done("flush_nodone", 40);
    run_op(DIVU, 32'd1000, 32'd3, 32'd333, 33, "divu_after_flush");

    run_op(DIV,  32'd5, 32'd0, 32'hFFFFFFFF, 1, "div_by0");
    run_op(REM,  32'd5, 32'd0, 32'd5, 1, "rem_by0");
    run_op(DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
    run_op(REM,  32'h80000000, 32'hFFFFFFFF, 32'd0, 1, "rem_ovf");
    run_op(DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33, "divu_big");

    // A start pulse while busy must be ignored.
    @(negedge clk);
    op = DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
    tick(1);
    start = 1'b0;
    lat = 1;
    tick(4);
    lat += 4;
    op = DIVU; a = 32'd9; b = 32'd3; start = 1'b1;
    tick(1);
    lat++;
    start = 1'b0;
    while (!done && lat < 40) begin
      tick(1);
      lat++;
    end
    check_eq("busy_start_lat", lat, 33);
    check_eq("busy_start_res", result, 32'd142);
    watch_no_done("busy_start_norestart", 5);

    // Flush and start together in IDLE: start dropped.
    @(negedge clk);
    op = DIVU; a = 32'd50; b = 32'd5; start = 1'b1; flush = 1'b1;
    tick(1);
    start = 1'b0; flush = 1'b0;
    check_eq("flush_start_busy", {31'b0, busy}, 32'd0);
    watch_no_done("flush_start_nodone", 3);
    check_eq("flush_start_res", result, 32'd142);

    run_op(DIV,  32'd1000, 32'hFFFFFFFD, 32'hFFFFFEB3, 33, "c_div");
    run_op(REM,  32'd1000, 32'hFFFFFFFD, 32'd1, HIT_LAT, "c_rem");
    run_op(DIVU, 32'd1000, 32'hFFFFFFFD, 32'd0, 33, "c_divu");
    run_op(DIV,  32'd1000, 32'hFFFFFFFD, 32'hFFFFFEB3, 33, "c_div2");

    // Asynchronous reset in cycle 20 of an operation.
    @(negedge clk);
    op = DIVU; a = 32'd12345; b = 32'd10; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(19);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_busy", {31'b0, busy}, 32'd0);
    check_eq("arst_done", {31'b0, done}, 32'd0);
    check_eq("arst_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    watch_no_done("arst_nodone", 40);
    run_op(REM, 32'd1000, 32'hFFFFFFFD, 32'd1, 33, "rem_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
